// File: rtl/mem_responder_if.sv
// mem_responder_if -- request/response bus between an initiator and a
// single-outstanding memory responder.
//
//   req_valid  initiator -> responder  request present
//   req_ready  responder -> initiator  responder can accept this cycle
//   req_we     initiator -> responder  1 = write, 0 = read
//   req_addr   initiator -> responder  byte address
//   req_wdata  initiator -> responder  write data
//   req_be     initiator -> responder  byte enables, bit i covers wdata[8i+7:8i]
//   rsp_valid  responder -> initiator  response present
//   rsp_ready  initiator -> responder  initiator takes the response
//   rsp_rdata  responder -> initiator  read data (0 for writes and errors)
//   rsp_err    responder -> initiator  misaligned or out-of-range request
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder -- word-addressed 32-bit memory behind a valid/ready request
// and response handshake. One request is outstanding at a time; the response
// appears a fixed LATENCY edges after acceptance (LATENCY = 1 responds on the
// accepting edge itself) and is held until the initiator takes it.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, 2..65536)
//   LATENCY      acceptance-to-response latency in cycles (1..15)
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   bus          mem_responder_if slave side (request and response channels)
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        accept;
    logic        to_resp;
    logic        wr_en;

    // Request being completed: straight from the bus when LATENCY = 1 finishes
    // on the accepting edge, otherwise from the captured copy.
    logic        cur_we;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_be;
    logic        cur_err;
    logic [AW-1:0] cur_idx;

    logic [31:0] mem [DEPTH_WORDS];

    assign bus.req_ready = (state_q == IDLE) && !rst;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    assign accept = bus.req_valid && bus.req_ready;

    always_comb begin
        if (state_q == IDLE) begin
            cur_we    = bus.req_we;
            cur_addr  = bus.req_addr;
            cur_wdata = bus.req_wdata;
            cur_be    = bus.req_be;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_be    = be_q;
        end
    end

    assign cur_err = (cur_addr[1:0] != 2'b00) ||
                     ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign cur_idx = cur_addr[AW+1:2];

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        to_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        to_resp = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    to_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response payload is latched on the edge that enters RESP and then held.
    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (to_resp) begin
            err_d   = cur_err;
            rdata_d = (cur_we || cur_err) ? 32'd0 : mem[cur_idx];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                be_q    <= bus.req_be;
            end
        end
    end

    // A write lands only on the edge that enters RESP; gating with rst keeps
    // an abandoned request from reaching the array.
    assign wr_en = to_resp && cur_we && !cur_err && !rst;

    // NOTE: the array is deliberately not reset; contents are undefined until
    // written, which lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_be[b]) begin
                    mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
                end
            end
        end
    end
endmodule
